// File: rtl/fmul_arbiter_pkg.sv
// fmul_arb_pkg: shared types and constants for the fmul_arbiter block.
//   - FMUL_W       : operand/result byte width of the shared FMUL_v unit.
//   - ST_*         : state encodings used by the arbiter FSM.
//   - state_e      : FSM state type (IDLE -> ISSUE -> CAPTURE -> IDLE).
//   - fmul_carry() : AVR FMUL C flag, bit 15 of the unshifted product.
// Optional feature macro: FMUL_ARB_CARRY_EN (fmul_carry is only used when set).
package fmul_arb_pkg;

  localparam int FMUL_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    CAPTURE = ST_CAPTURE
  } state_e;

  // FMUL_v only exports the product shifted left by one, which drops the top
  // bit; recover it from the operands directly.
  function automatic logic fmul_carry(input logic [FMUL_W-1:0] a,
                                      input logic [FMUL_W-1:0] b);
    logic [2*FMUL_W-1:0] p;
    p = {{FMUL_W{1'b0}}, a} * {{FMUL_W{1'b0}}, b};
    return p[2*FMUL_W-1];
  endfunction

endpackage

// File: rtl/fmul_arbiter_if.sv
// fmul_arbiter_if: requester-side bus of fmul_arbiter.
//   i_req / i_rd_bus / i_rr_bus : request levels and packed operands
//                                 (requester k uses bits [8k+7:8k]).
//   o_gnt / o_valid             : one-hot grant and result-valid pulses.
//   o_tag, o_r1, o_r0, o_busy   : winner index, result bytes, busy flag.
//   o_c                         : FMUL carry, only with FMUL_ARB_CARRY_EN.
// Modports: slave = arbiter side, master = requester side.
interface fmul_arbiter_if
  import fmul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        i_req;
  logic [FMUL_W*N_REQ-1:0] i_rd_bus;
  logic [FMUL_W*N_REQ-1:0] i_rr_bus;
  logic [N_REQ-1:0]        o_gnt;
  logic [N_REQ-1:0]        o_valid;
  logic [IDX_W-1:0]        o_tag;
  logic [FMUL_W-1:0]       o_r1;
  logic [FMUL_W-1:0]       o_r0;
  logic                    o_busy;
`ifdef FMUL_ARB_CARRY_EN
  logic                    o_c;
`endif

  modport slave (
    input  i_req, i_rd_bus, i_rr_bus,
`ifdef FMUL_ARB_CARRY_EN
    output o_c,
`endif
    output o_gnt, o_valid, o_tag, o_r1, o_r0, o_busy
  );

  modport master (
    output i_req, i_rd_bus, i_rr_bus,
`ifdef FMUL_ARB_CARRY_EN
    input  o_c,
`endif
    input  o_gnt, o_valid, o_tag, o_r1, o_r0, o_busy
  );

endinterface

// File: rtl/fmul_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_i    : request vector.
//   ptr_i    : highest-priority index for this search.
//   any_o    : at least one request is set.
//   winner_o : first set bit found searching ptr_i, ptr_i+1, ... modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] idx_s;

  // Rotating first-set search; the extra sum bit handles the wrap for any N_REQ.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    sum_s    = '0;
    idx_s    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum_s = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum_s >= (IDX_W+1)'(N_REQ)) begin
        sum_s = sum_s - (IDX_W+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDX_W-1:0];
      if (!any_o && req_i[idx_s]) begin
        any_o    = 1'b1;
        winner_o = idx_s;
      end else begin
        any_o    = any_o;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one external FMUL_v multiplier.
//   i_clk, i_rst        : clock (rising edge), synchronous active-high reset.
//   bus (slave)         : requester bus, see fmul_arbiter_if.
//   o_fmul_rd/o_fmul_rr : registered operands driven to the shared FMUL_v.
//   i_fmul_r1/i_fmul_r0 : shifted product returned by FMUL_v.
// Operation: IDLE samples requests and latches the winner's operands, ISSUE
// pulses o_gnt and captures the product, CAPTURE pulses o_valid and advances
// the round-robin pointer past the winner.
// Optional feature macro: FMUL_ARB_CARRY_EN adds bus.o_c (FMUL C flag).
module fmul_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fmul_arbiter_if.slave     bus,
  output logic [FMUL_W-1:0] o_fmul_rd,
  output logic [FMUL_W-1:0] o_fmul_rr,
  input  logic [FMUL_W-1:0] i_fmul_r1,
  input  logic [FMUL_W-1:0] i_fmul_r0
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  tag_q, tag_d;
  logic [FMUL_W-1:0] rd_q, rd_d;
  logic [FMUL_W-1:0] rr_q, rr_d;
  logic [FMUL_W-1:0] r1_q, r1_d;
  logic [FMUL_W-1:0] r0_q, r0_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  valid_q, valid_d;
  logic              busy_q, busy_d;
`ifdef FMUL_ARB_CARRY_EN
  logic              c_q, c_d;
`endif

  logic              any_s;
  logic [IDX_W-1:0]  win_s;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (bus.i_req),
    .ptr_i    (ptr_q),
    .any_o    (any_s),
    .winner_o (win_s)
  );

  // Next-state and output decode; gnt/valid/busy are registered so they
  // line up with the state they describe.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    rd_d    = rd_q;
    rr_d    = rr_q;
    r1_d    = r1_q;
    r0_d    = r0_q;
    gnt_d   = '0;
    valid_d = '0;
`ifdef FMUL_ARB_CARRY_EN
    c_d     = c_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d      = ISSUE;
          tag_d        = win_s;
          rd_d         = bus.i_rd_bus[int'(win_s)*FMUL_W +: FMUL_W];
          rr_d         = bus.i_rr_bus[int'(win_s)*FMUL_W +: FMUL_W];
          gnt_d[win_s] = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // FMUL_v has settled on rd_q/rr_q during this cycle.
        r1_d           = i_fmul_r1;
        r0_d           = i_fmul_r0;
`ifdef FMUL_ARB_CARRY_EN
        c_d            = fmul_carry(rd_q, rr_q);
`endif
        valid_d[tag_q] = 1'b1;
        state_d        = CAPTURE;
      end
      CAPTURE: begin
        if (tag_q == IDX_W'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = tag_q + IDX_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tag_q   <= '0;
      rd_q    <= '0;
      rr_q    <= '0;
      r1_q    <= '0;
      r0_q    <= '0;
      gnt_q   <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
`ifdef FMUL_ARB_CARRY_EN
      c_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
      rr_q    <= rr_d;
      r1_q    <= r1_d;
      r0_q    <= r0_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef FMUL_ARB_CARRY_EN
      c_q     <= c_d;
`endif
    end
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_valid = valid_q;
  assign bus.o_tag   = tag_q;
  assign bus.o_r1    = r1_q;
  assign bus.o_r0    = r0_q;
  assign bus.o_busy  = busy_q;
  assign o_fmul_rd   = rd_q;
  assign o_fmul_rr   = rr_q;
`ifdef FMUL_ARB_CARRY_EN
  assign bus.o_c     = c_q;
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter (N_REQ = 4). Provides the FMUL_v stand-in,
// runs directed scenarios and a randomized phase, and compares every cycle
// against a transaction-level reference model. Honors FMUL_ARB_CARRY_EN.
module tb_fmul_arbiter;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [8*N-1:0] rd_bus, rr_bus;
  logic [7:0]   fmul_rd, fmul_rr, fmul_r1, fmul_r0;
  logic [15:0]  fm_raw;

  fmul_arbiter_if #(.N_REQ(N)) bus ();

  assign bus.i_req    = req;
  assign bus.i_rd_bus = rd_bus;
  assign bus.i_rr_bus = rr_bus;

  // FMUL_v stand-in: unsigned 1.7 x 1.7, product shifted left by one.
  assign fm_raw = {8'd0, fmul_rd} * {8'd0, fmul_rr};
  assign {fmul_r1, fmul_r0} = {fm_raw[14:0], 1'b0};

  fmul_arbiter #(.N_REQ(N)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_fmul_rd (fmul_rd),
    .o_fmul_rr (fmul_rr),
    .i_fmul_r1 (fmul_r1),
    .i_fmul_r0 (fmul_r0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: one operation in flight at most.
  int m_ptr, m_free, m_pend, m_w, edge_n;
  int e_tag, e_rd, e_rr, e_r1, e_r0, e_c;
  int gnt_log[$];
  int vcount[N];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic set_op(input int k, input int rd, input int rr);
    rd_bus[8*k +: 8] = rd[7:0];
    rr_bus[8*k +: 8] = rr[7:0];
  endtask

  // One clock: predict what the coming edge does, then compare all outputs.
  task automatic tick();
    int exp_gnt, exp_valid, exp_busy, k, prod;
    bit found;
    edge_n++;
    if (rst) begin
      m_ptr = 0; m_free = 0; m_pend = -100;
      e_tag = 0; e_rd = 0; e_rr = 0; e_r1 = 0; e_r0 = 0; e_c = 0;
    end else begin
      if (edge_n == m_pend + 1) begin
        prod = e_rd * e_rr;
        e_r1 = ((prod * 2) / 256) % 256;
        e_r0 = (prod * 2) % 256;
        e_c  = prod / 32768;
      end
      if (edge_n >= m_free && req != '0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (!found && req[k]) begin
            found = 1'b1;
            m_w = k;
          end
        end
        m_pend = edge_n;
        m_free = edge_n + 3;
        m_ptr  = (m_w + 1) % N;
        e_tag  = m_w;
        e_rd   = int'(rd_bus[8*m_w +: 8]);
        e_rr   = int'(rr_bus[8*m_w +: 8]);
      end
    end
    exp_gnt   = (edge_n == m_pend)     ? (1 << m_w) : 0;
    exp_valid = (edge_n == m_pend + 1) ? (1 << m_w) : 0;
    exp_busy  = (edge_n == m_pend || edge_n == m_pend + 1) ? 1 : 0;
    @(posedge clk);
    #1;
    check_val("gnt",     32'(bus.o_gnt),   exp_gnt);
    check_val("valid",   32'(bus.o_valid), exp_valid);
    check_val("busy",    32'(bus.o_busy),  exp_busy);
    check_val("tag",     32'(bus.o_tag),   e_tag);
    check_val("r1",      32'(bus.o_r1),    e_r1);
    check_val("r0",      32'(bus.o_r0),    e_r0);
    check_val("fmul_rd", 32'(fmul_rd),     e_rd);
    check_val("fmul_rr", 32'(fmul_rr),     e_rr);
`ifdef FMUL_ARB_CARRY_EN
    check_val("c",       32'(bus.o_c),     e_c);
`endif
    for (int j = 0; j < N; j++) begin
      if (bus.o_gnt[j]) gnt_log.push_back(j);
      if (bus.o_valid[j]) vcount[j]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single request from requester k with directed expected result.
  task automatic run_single(input int k, input int rd, input int rr,
                            input int x1, input int x0, input int xc);
    set_op(k, rd, rr);
    req = '0;
    req[k] = 1'b1;
    tick();
    check_val("single_gnt", 32'(bus.o_gnt), 32'(1 << k));
    req = '0;
    tick();
    check_val("single_valid", 32'(bus.o_valid), 32'(1 << k));
    check_val("single_r1", 32'(bus.o_r1), x1);
    check_val("single_r0", 32'(bus.o_r0), x0);
    check_val("single_tag", 32'(bus.o_tag), k);
`ifdef FMUL_ARB_CARRY_EN
    check_val("single_c", 32'(bus.o_c), xc);
`endif
    tick();
    check_val("single_idle", 32'(bus.o_busy), 0);
  endtask

  task automatic check_order(input string tag, input int e0, input int e1,
                             input int e2, input int e3);
    int exp_q[4];
    int obs;
    exp_q = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      obs = (i < gnt_log.size()) ? gnt_log[i] : -1;
      check_val(tag, obs, exp_q[i]);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; rd_bus = '0; rr_bus = '0;
    edge_n = 0; m_pend = -100; m_ptr = 0; m_free = 0; m_w = 0;
    e_tag = 0; e_rd = 0; e_rr = 0; e_r1 = 0; e_r0 = 0; e_c = 0;

    do_reset();
    check_val("rst_gnt", 32'(bus.o_gnt), 0);
    check_val("rst_r1r0", {16'd0, bus.o_r1, bus.o_r0}, 0);

    // Directed single operations.
    run_single(0, 'h4C, 'h59, 'h34, 'hD8, 0);
    run_single(2, 'h80, 'h80, 'h80, 'h00, 0);
    run_single(1, 'hFF, 'hFF, 'hFC, 'h02, 1);

    // Contention: all four requesting from reset, each drops after its grant.
    rst = 1'b1;
    req = '1;
    for (int k = 0; k < N; k++) set_op(k, 'h01, 'h01);
    tick(); tick();
    rst = 1'b0;
    gnt_log.delete();
    for (int k = 0; k < N; k++) vcount[k] = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int k = 0; k < N; k++) if (bus.o_gnt[k]) req[k] = 1'b0;
    end
    check_val("cont_ngnt", gnt_log.size(), 4);
    check_order("cont_order", 0, 1, 2, 3);
    for (int k = 0; k < N; k++) check_val("cont_valid_cnt", vcount[k], 1);
    check_val("cont_r1r0", {16'd0, bus.o_r1, bus.o_r0}, 'h0002);

    // Fairness: requesters 0 and 3 held high permanently.
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, 'h40, 'hC0);
    req = 4'b1001;
    gnt_log.delete();
    for (int c = 0; c < 13; c++) tick();
    check_order("fair_order", 0, 3, 0, 3);
    foreach (gnt_log[i]) check_val("fair_only03", (gnt_log[i] == 0 || gnt_log[i] == 3), 1);
    check_val("fair_r1r0", {16'd0, bus.o_r1, bus.o_r0}, 'h6000);

    // Reset during ISSUE discards the operation.
    req = '0;
    tick(); tick(); tick();
    set_op(3, 'h33, 'h44);
    req = 4'b1000;
    tick();
    check_val("rmid_gnt", 32'(bus.o_gnt), 'h8);
    req = '0;
    rst = 1'b1;
    tick();
    check_val("rmid_valid", 32'(bus.o_valid), 0);
    check_val("rmid_outs", {bus.o_r1, bus.o_r0, fmul_rd, fmul_rr}, 0);
    check_val("rmid_tagbusy", {30'd0, bus.o_tag}, 0);
    rst = 1'b0;
    set_op(1, 'h4C, 'h59);
    req = 4'b1010;
    tick();
    check_val("rmid_regnt", 32'(bus.o_gnt), 'h2);
    req = 4'b1000;
    tick();
    check_val("rmid_rvalid", 32'(bus.o_valid), 'h2);
    req = '0;
    tick(); tick(); tick(); tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N; k++) begin
        if (!req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_op(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            req[k] = 1'b1;
          end
        end else if (bus.o_gnt[k]) begin
          req[k] = $urandom_range(0, 1) == 1;
        end else if ($urandom_range(0, 31) == 0) begin
          req[k] = 1'b0;
        end
      end
      tick();
    end
    rst = 1'b0;
    req = '0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Shares one combinational FMUL_v fractional multiplier (8-bit x 8-bit, 1.7 fixed point, product shifted left by 1 into r1:r0) between N_REQ requesters.
- Arbitration is round-robin. The block registers the winner's operands, drives the shared multiplier, captures the product, and returns it to the winner with a one-cycle valid pulse.
- FMUL_v is instantiated at the parent level and connected through the o_fmul_* / i_fmul_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(N_REQ), width of the requester index.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  N_REQ  per-requester request level.
- i_rd_bus  in  8*N_REQ  multiplicand; requester k uses bits [8k+7:8k].
- i_rr_bus  in  8*N_REQ  multiplier; same packing as i_rd_bus.
- o_gnt  out  N_REQ  one-hot grant pulse (operands accepted).
- o_valid  out  N_REQ  one-hot result-valid pulse.
- o_tag  out  IDX_W  index of the current or last winner.
- o_r1  out  8  result high byte.
- o_r0  out  8  result low byte.
- o_busy  out  1  high when state is not IDLE.
- o_fmul_rd  out  8  operand to the shared FMUL_v.
- o_fmul_rr  out  8  operand to the shared FMUL_v.
- i_fmul_r1  in  8  product high byte from FMUL_v.
- i_fmul_r0  in  8  product low byte from FMUL_v.

Behaviour:
- Reset: the following outputs are 0 — o_gnt, o_valid, o_tag, o_r1, o_r0, o_busy, o_fmul_rd, o_fmul_rr.
- Reset: state = IDLE; round-robin pointer ptr = 0.
- i_rst has priority over every event, including mid-operation. An in-flight operation is discarded and no o_valid is issued.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE. Each state lasts exactly one cycle.
- IDLE: i_req is sampled only in this state. If any bit is set, the winner w is the first set bit searching ptr, ptr+1, ..., wrapping modulo N_REQ.
- IDLE, on that edge: latch w's operands into o_fmul_rd/o_fmul_rr, set o_tag = w, and go to ISSUE. With no request, stay in IDLE.
- ISSUE: o_gnt[w] = 1 for this cycle. FMUL_v output settles combinationally. On the edge, o_r1/o_r0 <= i_fmul_r1/i_fmul_r0, then go to CAPTURE.
- CAPTURE: o_valid[w] = 1 for this cycle. On the edge, ptr <= (w+1) mod N_REQ, then go to IDLE.
- Latency: request sampled at edge t -> o_gnt in cycle t+1 -> o_valid in cycle t+2. Peak throughput is one operation per 3 cycles.
- Requester obligation: hold i_req and its operands stable until o_gnt is seen.
- A request still high when the FSM next returns to IDLE counts as a new request.
- Requests that drop before being sampled are lost. This is not an error.
- Simultaneous requests: only one grant is given per operation. Losers keep waiting; round-robin rotation prevents starvation.
- Worst-case wait is N_REQ-1 operations.
- o_r1, o_r0, o_tag, o_fmul_rd and o_fmul_rr hold their values until overwritten.
- At most one bit of o_gnt|o_valid is set in any cycle.
- o_busy = (state != IDLE).
- Arithmetic is owned by FMUL_v. The arbiter passes the product through unmodified.

Optional Feature:
- Macro: FMUL_ARB_CARRY_EN.
- When defined: adds output port o_c (1 bit, reset 0). o_c is registered alongside o_r1/o_r0 in ISSUE.
- o_c is bit 15 of the unshifted 16-bit product, i.e. the AVR FMUL C flag. It is recovered as bit 15 of the full 16-bit product computed from o_fmul_rd * o_fmul_rr.
- It is computed internally because FMUL_v exports only the shifted product.
- When not defined: the o_c port and its multiplier logic do not exist.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package fmul_arb_pkg:
  - state enum: IDLE, ISSUE, CAPTURE.
  - FMUL_W = 8.
  - localparams for the state encodings.
- One sub-module: rr_picker (combinational).
  - Inputs: req vector, ptr.
  - Outputs: any, winner index.
- The FSM, operand mux and result registers stay in fmul_arbiter.

Test Plan:
1. Single requester: req[0], rd=0x4C, rr=0x59.
   - Expected: gnt[0] in cycle t+1, valid[0] in cycle t+2, r1:r0 = 0x34:0xD8.
2. req[2], rd=0x80, rr=0x80.
   - Expected: r1:r0 = 0x80:0x00, tag=2.
   - With FMUL_ARB_CARRY_EN: c=0.
3. req[1], rd=0xFF, rr=0xFF.
   - Expected: r1:r0 = 0xFC:0x02.
   - With FMUL_ARB_CARRY_EN: c=1.
4. Contention: all four req held high from reset, each requester dropping its req after its own gnt.
   - Expected grant order: 0, 1, 2, 3, with exactly one valid pulse each.
   - Operand case: rd=0x01, rr=0x01 gives r1:r0 = 0x00:0x02.
5. Fairness: req[0] and req[3] held permanently high.
   - Expected grants alternate 0, 3, 0, 3.
   - No other gnt bits fire.
   - Operand case: rd=0x40, rr=0xC0 gives r1:r0 = 0x60:0x00.
6. Reset mid-operation: assert i_rst during ISSUE.
   - Expected: no o_valid in the next cycle, all outputs 0, ptr = 0.
   - The next request from req[1] is granted normally.
